// File: rtl/text_writer.sv
// Character-cell text RAM writer: byte stream with CR/LF/BS handling, cursor tracking and a clear-to-spaces fill engine.
// Optional build macro CLEAR_ON_RESET_EN: clear the whole screen automatically after reset release.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | accepting bytes from the stream
// S_CLEAR | fill engine writing spaces, then one closing cycle
// S_BOOT  | one cycle after reset release before the boot-time clear
module text_writer #(
   parameter int COLS   = 80,
   parameter int ROWS   = 25,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              clear_req,
   output logic              busy,
   output logic              write_en,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] din,
   output logic [6:0]        cur_col,
   output logic [4:0]        cur_row
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_BOOT
   } state_e;

   localparam int                FW       = ADDR_W + 1;
   localparam int                TOTAL    = COLS * ROWS;
   localparam logic [FW-1:0]     FILL_END = FW'(TOTAL);
   localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
   localparam logic [4:0]        ROW_LAST = 5'(ROWS - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] LF_WRAP  = ADDR_W'((ROWS - 1) * COLS);
   localparam logic [DATA_W-1:0] SPACE    = DATA_W'(8'h20);

`ifdef CLEAR_ON_RESET_EN
   localparam state_e RESET_STATE = S_BOOT;
`else
   localparam state_e RESET_STATE = S_IDLE;
`endif

   state_e              state_q, state_d;
   logic [6:0]          col_q, col_d;
   logic [4:0]          row_q, row_d;
   logic [ADDR_W-1:0]   lin_q, lin_d;
   logic [FW-1:0]       fill_q, fill_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                accept;

   assign in_ready = (state_q == S_IDLE) && !clear_req;
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q == S_CLEAR);
   assign write_en = we_q;
   assign waddr    = waddr_q;
   assign din      = din_q;
   assign cur_col  = col_q;
   assign cur_row  = row_q;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      lin_d   = lin_q;
      fill_d  = fill_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      din_d   = din_q;

      unique case (state_q)
         S_IDLE: begin
            if (clear_req) begin
               // the first fill write leaves on the same edge the request is taken
               state_d = S_CLEAR;
               we_d    = 1'b1;
               waddr_d = '0;
               din_d   = SPACE;
               fill_d  = FW'(1);
            end else if (accept) begin
               unique case (in_data)
                  8'h0D: begin
                     col_d = '0;
                     lin_d = lin_q - ADDR_W'(col_q);
                  end
                  8'h0A: begin
                     if (row_q == ROW_LAST) begin
                        row_d = '0;
                        lin_d = lin_q - LF_WRAP;
                     end else begin
                        row_d = row_q + 5'd1;
                        lin_d = lin_q + ROW_STEP;
                     end
                  end
                  8'h08: begin
                     if (col_q != 7'd0) begin
                        col_d = col_q - 7'd1;
                        lin_d = lin_q - ADDR_W'(1);
                     end
                  end
                  default: begin
                     we_d    = 1'b1;
                     waddr_d = lin_q;
                     din_d   = DATA_W'(in_data);
                     if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                           row_d = '0;
                           lin_d = '0;
                        end else begin
                           row_d = row_q + 5'd1;
                           lin_d = lin_q + ADDR_W'(1);
                        end
                     end else begin
                        col_d = col_q + 7'd1;
                        lin_d = lin_q + ADDR_W'(1);
                     end
                  end
               endcase
            end
         end
         S_BOOT: begin
            state_d = S_CLEAR;
            we_d    = 1'b1;
            waddr_d = '0;
            din_d   = SPACE;
            fill_d  = FW'(1);
         end
         S_CLEAR: begin
            // one closing cycle after the last write keeps busy high until that write is done
            if (fill_q == FILL_END) begin
               state_d = S_IDLE;
               col_d   = '0;
               row_d   = '0;
               lin_d   = '0;
               fill_d  = '0;
            end else begin
               we_d    = 1'b1;
               waddr_d = fill_q[ADDR_W-1:0];
               din_d   = SPACE;
               fill_d  = fill_q + FW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= RESET_STATE;
         col_q   <= '0;
         row_q   <= '0;
         lin_q   <= '0;
         fill_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         lin_q   <= lin_d;
         fill_q  <= fill_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         din_q   <= din_d;
      end
   end

endmodule

// File: doc/text_writer.md
# text_writer

Sequences writes into the character-cell text RAM that feeds the font renderer. Accepts a byte stream over a valid/ready handshake, interprets a small set of control codes, and tracks the cursor position. Drives the RAM write port (write_en/waddr/din) and owns a fill engine that clears the screen to spaces. The display side keeps exclusive use of the RAM read port.

## Interface
- COLS, 80: characters per row
- ROWS, 25: rows per screen; COLS*ROWS ≤ 2^ADDR_W
- ADDR_W, 11: RAM address width
- DATA_W, 8: RAM data width; bytes are zero-extended if wider than 8

- clk  in  1  single clock for all logic and for the RAM write port
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data holds a byte to process
- in_data  in  8  character or control code
- in_ready  out  1  byte accepted at this rising edge when in_valid && in_ready
- clear_req  in  1  single-cycle request to clear the screen
- busy  out  1  clear in progress
- write_en  out  1  RAM write strobe
- waddr  out  ADDR_W  RAM write address
- din  out  DATA_W  RAM write data
- cur_col  out  7  cursor column, 0..COLS-1
- cur_row  out  5  cursor row, 0..ROWS-1

## Operation
- FSM states:
  - IDLE: accepts bytes.
  - CLEAR: fill engine runs.
- in_ready = (state==IDLE) && !clear_req. This is combinational; a clear request always wins over a byte offered in the same cycle.
- Cursor state:
  - Cursor is held as cur_col and cur_row plus a linear address register lin = cur_row*COLS + cur_col.
  - lin is maintained incrementally. No multiplier is used.
- Accepted byte handling:
  - 0x0D (CR): cur_col=0, lin -= old cur_col. No write.
  - 0x0A (LF): cur_row = (cur_row+1) mod ROWS, lin adjusted to match. Column is unchanged. No write. There is no scrolling.
  - 0x08 (BS): if cur_col>0, cur_col-1 and lin-1. At column 0 nothing changes. No write.
  - Any other byte: written at lin, then the cursor advances.
    - cur_col==COLS-1: cur_col=0 and the row increments.
    - Row ROWS-1 wraps to row 0 and lin wraps to 0.
- Clear:
  - In IDLE, clear_req=1 moves the FSM to CLEAR at the next edge.
  - CLEAR writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle, ascending.
  - After the last write the cursor goes to (0,0), lin=0, and the FSM returns to IDLE.
  - clear_req while in CLEAR is ignored; the clear does not restart.
- Reset:
  - Outputs reset to: write_en=0, waddr=0, din=0, busy=0, cur_col=0, cur_row=0.
  - in_ready=1 once resetn is high, unless CLEAR_ON_RESET_EN is defined (see Configuration).
  - Reset asserted mid-clear aborts the clear immediately. Partially cleared RAM contents are left as they are.

## Timing
- Write outputs (write_en, waddr, din) are registered.
- A printable byte accepted at edge N produces write_en=1 with the old cursor address during cycle N+1. Cursor outputs update at edge N.
- Throughput is one byte per cycle, with no bubbles for back-to-back printable bytes.
- Control codes update the cursor at the accept edge and produce no write cycle.
- Clear timing:
  - clear_req seen at edge N: busy=1 from N.
  - First fill write (waddr=0) occurs during cycle N+1.
  - Last write (waddr=COLS*ROWS-1) occurs during cycle N+COLS*ROWS.
  - busy=0 and in_ready=1 from edge N+COLS*ROWS. The clear takes exactly COLS*ROWS write cycles (2000 at defaults).
- write_en is never asserted on two sources in the same cycle: the byte path and the fill engine are exclusive by state.

## Configuration
- CLEAR_ON_RESET_EN
  - Defined: on release of resetn the FSM enters CLEAR instead of IDLE and performs a full clear. busy=1 and in_ready=0 from the first edge after reset until the clear completes.
  - Not defined: the FSM leaves reset in IDLE and RAM contents are untouched, so the preloaded RAM image stays visible.

## Test plan
- Byte 0x41 accepted at reset cursor -> one cycle later write_en=1, waddr=0, din=0x41. Then cur_col=1, cur_row=0.
- Cursor at (79,0), byte 0x42 -> write at waddr=79, cursor becomes (0,1). Cursor at (79,24), byte 0x43 -> write at waddr=1999, cursor becomes (0,0).
- Cursor at (5,3): send 0x0D, 0x0A, 0x08 -> cursor (0,3), then (0,4), then (0,4) unchanged. No write_en pulses.
- clear_req and in_valid (0x58) in the same cycle -> in_ready=0, the byte is not consumed. Exactly 2000 writes of 0x20 at addresses 0..1999. busy deasserts after the 2000th write, cursor is (0,0), and 0x58 is then accepted and written to address 0.
- resetn pulsed low during a clear at address 700 -> write_en=0 immediately, busy=0, cursor (0,0). Without CLEAR_ON_RESET_EN no further writes occur.
- With CLEAR_ON_RESET_EN -> after reset release, busy=1 and exactly 2000 writes of 0x20 before in_ready first goes high.
